warp_scheduler: RTL and testbench

Time-multiplexes THREAD_NUMBER logical threads onto a shared array of LANES physical kernel instances, so a batch no longer needs one kernel per thread.
- Loads a batch of 16-bit samples from the host-to-card FIFO, two per 32-bit word.
- Issues them group by group to the lanes and collects one result per lane.
- Streams packed results into the card-to-host FIFO.
- Sits between the Xillybus FIFO pair and the kernel lane array; the top level wires it up.

---
 rtl/warp_scheduler.sv | 177 +++++++++++++++++
 tb/tb_warp_scheduler.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/warp_scheduler.sv
// Time-multiplexes THREAD_NUMBER logical threads onto LANES physical kernel lanes,
// moving samples from the host-to-card FIFO and results back to the card-to-host FIFO.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | reading THREAD_NUMBER/2 packed words into sbuf
// ISSUE  | one-cycle operand broadcast for group g
// WAIT   | collecting one result per lane for group g
// UNLOAD | writing packed results from rbuf
module warp_scheduler #(
   parameter int THREAD_NUMBER = 256,
   parameter int LANES         = 16,
   parameter int TIMEOUT       = 1023
) (
   input  logic                 bus_clk,
   input  logic                 bus_rst_n,
   input  logic                 abort,
   input  logic                 start,
   output logic                 rx_rden,
   input  logic [31:0]          rx_data,
   input  logic                 rx_valid,
   output logic                 tx_wren,
   output logic [31:0]          tx_data,
   input  logic                 tx_full,
   output logic [16*LANES-1:0]  lane_in_data,
   output logic [LANES-1:0]     lane_in_valid,
   input  logic [16*LANES-1:0]  lane_out_data,
   input  logic [LANES-1:0]     lane_out_valid,
   output logic                 busy,
   output logic                 done,
   output logic                 timeout_err
);

   localparam int WORDS  = THREAD_NUMBER / 2;
   localparam int GROUPS = THREAD_NUMBER / LANES;
   localparam int IW     = $clog2(THREAD_NUMBER);
   localparam int CW     = $clog2(WORDS) + 1;
   localparam int GW     = $clog2(GROUPS) + 1;
   localparam int TW     = $clog2(TIMEOUT) + 1;

   localparam logic [CW-1:0] WORDS_C = CW'(WORDS);
   localparam logic [CW-1:0] LAST_K  = CW'(WORDS - 1);
   localparam logic [GW-1:0] LAST_G  = GW'(GROUPS - 1);
   localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_UNLOAD} state_t;

   state_t            state;
   logic [CW-1:0]     req_cnt;
   logic [CW-1:0]     rcv_cnt;
   logic [CW-1:0]     send_k;
   logic [GW-1:0]     grp;
   logic [TW-1:0]     timer;
   logic [LANES-1:0]  flags;
   logic [LANES-1:0]  flags_nxt;
   logic [CW:0]       rcv_sum;

   logic [15:0] sbuf [THREAD_NUMBER];
   logic [15:0] rbuf [THREAD_NUMBER];

   // A word in flight shows up as rx_valid this cycle, so rcv_cnt+rx_valid is
   // everything that will ever arrive; re-request only when that falls short.
   assign rcv_sum   = {1'b0, rcv_cnt} + {{CW{1'b0}}, rx_valid};
   assign rx_rden   = (state == S_LOAD) && !abort &&
                      ((req_cnt < WORDS_C) || (rcv_sum < (CW+1)'(WORDS)));
   assign tx_wren   = (state == S_UNLOAD) && !tx_full && !abort;
   assign done      = tx_wren && (send_k == LAST_K);
   assign busy      = (state != S_IDLE);
   assign flags_nxt = flags | lane_out_valid;

   always_comb begin
      lane_in_data  = '0;
      lane_in_valid = '0;
      tx_data       = '0;
      if (state == S_ISSUE) begin
         lane_in_valid = '1;
         for (int i = 0; i < LANES; i++)
            lane_in_data[16*i +: 16] = sbuf[IW'(int'(grp) * LANES + i)];
      end
      if (state == S_UNLOAD)
         tx_data = {rbuf[IW'(2 * int'(send_k) + 1)], rbuf[IW'(2 * int'(send_k))]};
   end

   always_ff @(posedge bus_clk) begin
      if (state == S_LOAD && rx_valid) begin
         sbuf[IW'(2 * int'(rcv_cnt))]     <= rx_data[15:0];
         sbuf[IW'(2 * int'(rcv_cnt) + 1)] <= rx_data[31:16];
      end
      if (state == S_WAIT) begin
         for (int i = 0; i < LANES; i++)
            if (lane_out_valid[i])
               rbuf[IW'(int'(grp) * LANES + i)] <= lane_out_data[16*i +: 16];
      end
   end

   always_ff @(posedge bus_clk or negedge bus_rst_n) begin
      if (!bus_rst_n) begin
         state       <= S_IDLE;
         req_cnt     <= '0;
         rcv_cnt     <= '0;
         send_k      <= '0;
         grp         <= '0;
         timer       <= '0;
         flags       <= '0;
         timeout_err <= 1'b0;
      end else if (abort) begin
         state   <= S_IDLE;
         req_cnt <= '0;
         rcv_cnt <= '0;
         send_k  <= '0;
         grp     <= '0;
         timer   <= '0;
         flags   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state       <= S_LOAD;
                  timeout_err <= 1'b0;
                  req_cnt     <= '0;
                  rcv_cnt     <= '0;
                  send_k      <= '0;
                  grp         <= '0;
               end
            end
            S_LOAD: begin
               if (rx_rden && req_cnt < WORDS_C)
                  req_cnt <= req_cnt + 1'b1;
               if (rx_valid) begin
                  rcv_cnt <= rcv_cnt + 1'b1;
                  if (rcv_cnt == LAST_K)
                     state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               flags <= '0;
               timer <= '0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               flags <= flags_nxt;
               if (&flags_nxt) begin
                  if (grp == LAST_G) begin
                     state  <= S_UNLOAD;
                     send_k <= '0;
                  end else begin
                     grp   <= grp + 1'b1;
                     state <= S_ISSUE;
                  end
               end else if (timer == T_LAST) begin
                  timeout_err <= 1'b1;
                  state       <= S_IDLE;
                  req_cnt     <= '0;
                  rcv_cnt     <= '0;
                  grp         <= '0;
                  timer       <= '0;
                  flags       <= '0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            S_UNLOAD: begin
               if (tx_wren) begin
                  if (send_k == LAST_K) begin
                     state  <= S_IDLE;
                     send_k <= '0;
                  end else begin
                     send_k <= send_k + 1'b1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_warp_scheduler.sv
// Directed bench for warp_scheduler with 8 threads on 4 lanes; lanes return in+1
// after a per-lane latency, FIFOs are modelled with queues.
module tb_warp_scheduler;

   localparam int TN = 8;
   localparam int LN = 4;
   localparam int TO = 16;

   logic              bus_clk = 1'b0;
   logic              bus_rst_n = 1'b0;
   logic              abort = 1'b0;
   logic              start = 1'b0;
   logic              rx_rden;
   logic [31:0]       rx_data;
   logic              rx_valid;
   logic              tx_wren;
   logic [31:0]       tx_data;
   logic              tx_full = 1'b0;
   logic [16*LN-1:0]  lane_in_data;
   logic [LN-1:0]     lane_in_valid;
   logic [16*LN-1:0]  lane_out_data;
   logic [LN-1:0]     lane_out_valid;
   logic              busy;
   logic              done;
   logic              timeout_err;

   warp_scheduler #(.THREAD_NUMBER(TN), .LANES(LN), .TIMEOUT(TO)) dut (
      .bus_clk        (bus_clk),
      .bus_rst_n      (bus_rst_n),
      .abort          (abort),
      .start          (start),
      .rx_rden        (rx_rden),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .tx_wren        (tx_wren),
      .tx_data        (tx_data),
      .tx_full        (tx_full),
      .lane_in_data   (lane_in_data),
      .lane_in_valid  (lane_in_valid),
      .lane_out_data  (lane_out_data),
      .lane_out_valid (lane_out_valid),
      .busy           (busy),
      .done           (done),
      .timeout_err    (timeout_err)
   );

   always #5 bus_clk = ~bus_clk;

   logic [31:0] rxq [$];
   logic [31:0] txq [$];
   int          iss_log [$];
   int          l2_log [$];
   int          done_cnt = 0;
   int          cyc_g = 0;
   int          lat [LN];
   logic [15:0] pend_d [LN];
   int          pend_c [LN];

   always @(posedge bus_clk or negedge bus_rst_n) begin
      if (!bus_rst_n) begin
         rx_valid <= 1'b0;
         rx_data  <= '0;
      end else begin
         rx_valid <= 1'b0;
         if (rx_rden && rxq.size() > 0) begin
            rx_data  <= rxq.pop_front();
            rx_valid <= 1'b1;
         end
      end
   end

   always @(posedge bus_clk or negedge bus_rst_n) begin
      if (!bus_rst_n) begin
         for (int i = 0; i < LN; i++) begin
            pend_c[i] <= 0;
            pend_d[i] <= '0;
         end
      end else begin
         for (int i = 0; i < LN; i++) begin
            if (lane_in_valid[i]) begin
               pend_d[i] <= lane_in_data[16*i +: 16] + 16'd1;
               pend_c[i] <= lat[i];
            end else if (pend_c[i] > 0) begin
               pend_c[i] <= pend_c[i] - 1;
            end
         end
      end
   end

   always_comb begin
      lane_out_valid = '0;
      lane_out_data  = '0;
      for (int i = 0; i < LN; i++) begin
         lane_out_valid[i]         = (pend_c[i] == 1);
         lane_out_data[16*i +: 16] = pend_d[i];
      end
   end

   always @(posedge bus_clk) begin
      if (lane_in_valid[0]) iss_log.push_back(cyc_g);
      if (lane_out_valid[2]) l2_log.push_back(cyc_g);
      if (tx_wren) txq.push_back(tx_data);
      if (done) done_cnt++;
      cyc_g++;
   end

   int n_chk = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   logic [31:0] win  [4];
   logic [31:0] wexp [4];
   int tx_base, done_base, iss_base, l2_base;

   task automatic set_lat(input int a, input int b, input int c, input int d);
      lat[0] = a; lat[1] = b; lat[2] = c; lat[3] = d;
   endtask

   task automatic prep();
      for (int i = 0; i < 4; i++) rxq.push_back(win[i]);
      tx_base   = txq.size();
      done_base = done_cnt;
      iss_base  = iss_log.size();
      l2_base   = l2_log.size();
   endtask

   // Start at the current negedge (cycle 0) and return the cycle where done is seen.
   task automatic run_batch(input int spur, output int cyc);
      prep();
      start = 1'b1;
      @(negedge bus_clk);
      cyc = 1;
      start = (cyc == spur);
      while (!done && cyc < 300) begin
         @(negedge bus_clk);
         cyc++;
         start = (cyc == spur);
      end
      start = 1'b0;
      check_val("done_seen", done, 1);
      @(negedge bus_clk);
      check_val("busy_after_done", {busy, done}, 2'b00);
   endtask

   task automatic check_tx(input string tag);
      check_val({tag, "_count"}, txq.size() - tx_base, 4);
      for (int i = 0; i < 4; i++)
         if (tx_base + i < txq.size())
            check_val($sformatf("%s_w%0d", tag, i), txq[tx_base + i], wexp[i]);
      check_val({tag, "_done_cnt"}, done_cnt - done_base, 1);
   endtask

   int cyc;
   int hits;

   initial begin
      set_lat(3, 3, 3, 3);
      repeat (2) @(negedge bus_clk);
      check_val("rst_ctl", {busy, done, rx_rden, tx_wren, timeout_err, lane_in_valid}, '0);
      check_val("rst_data", {tx_data, lane_in_data}, '0);
      bus_rst_n = 1'b1;
      @(negedge bus_clk);

      // basic batch, with a spurious start while busy
      win  = '{32'h00010000, 32'h00030002, 32'h00050004, 32'h00070006};
      wexp = '{32'h00020001, 32'h00040003, 32'h00060005, 32'h00080007};
      run_batch(8, cyc);
      check_val("basic_latency", cyc, 17);
      check_tx("basic");

      // ragged: lane 2 answers 5 cycles after the others
      set_lat(3, 3, 8, 3);
      win  = '{32'h00200010, 32'h00400030, 32'h00600050, 32'h00800070};
      wexp = '{32'h00210011, 32'h00410031, 32'h00610051, 32'h00810071};
      run_batch(-1, cyc);
      check_val("ragged_latency", cyc, 27);
      check_tx("ragged");
      if (iss_log.size() >= iss_base + 2 && l2_log.size() > l2_base)
         check_val("ragged_issue2", iss_log[iss_base + 1] - l2_log[l2_base], 1);
      else
         check_val("ragged_logs", iss_log.size() - iss_base, 2);

      // backpressure mid-unload, including 16-bit wraparound in the lane model
      set_lat(1, 1, 1, 1);
      win  = '{32'h1234FFFF, 32'hABCD0000, 32'h7FFF8000, 32'h00FE00FF};
      wexp = '{32'h12350000, 32'hABCE0001, 32'h80008001, 32'h00FF0100};
      prep();
      start = 1'b1;
      @(negedge bus_clk);
      start = 1'b0;
      cyc = 1;
      while (txq.size() - tx_base < 2 && cyc < 100) begin
         @(negedge bus_clk);
         cyc++;
      end
      check_val("bp_two_written", txq.size() - tx_base, 2);
      tx_full = 1'b1;
      hits = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (tx_wren) hits++;
         @(negedge bus_clk);
      end
      check_val("bp_stall_wren", hits, 0);
      check_val("bp_stall_count", txq.size() - tx_base, 2);
      check_val("bp_busy", busy, 1);
      tx_full = 1'b0;
      cyc = 0;
      while (done_cnt == done_base && cyc < 100) begin
         @(negedge bus_clk);
         cyc++;
      end
      check_tx("bp");

      // timeout: lane 1 never responds
      set_lat(1, 0, 1, 1);
      win = '{32'h0000AAAA, 32'h0000BBBB, 32'h0000CCCC, 32'h0000DDDD};
      prep();
      start = 1'b1;
      @(negedge bus_clk);
      start = 1'b0;
      cyc = 1;
      while (!timeout_err && cyc < 100) begin
         @(negedge bus_clk);
         cyc++;
      end
      check_val("to_cycle", cyc, 23);
      check_val("to_state", {timeout_err, busy, done}, 3'b100);
      check_val("to_no_done", done_cnt - done_base, 0);
      check_val("to_no_tx", txq.size() - tx_base, 0);
      set_lat(2, 2, 2, 2);
      win  = '{32'h01000001, 32'h02000002, 32'h03000003, 32'h04000004};
      wexp = '{32'h01010002, 32'h02010003, 32'h03010004, 32'h04010005};
      run_batch(-1, cyc);
      check_val("to_restart_latency", cyc, 15);
      check_val("to_cleared", timeout_err, 0);
      check_tx("to_restart");

      // abort during load after two words
      set_lat(1, 1, 1, 1);
      win = '{32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003, 32'hDEAD0004};
      prep();
      start = 1'b1;
      @(negedge bus_clk);
      start = 1'b0;
      repeat (2) @(negedge bus_clk);
      abort = 1'b1;
      #1;
      check_val("ab_rden", {rx_rden, busy}, 2'b01);
      @(negedge bus_clk);
      abort = 1'b0;
      check_val("ab_idle", {busy, done, tx_wren}, 3'b000);
      check_val("ab_no_tx", txq.size() - tx_base, 0);
      rxq.delete();
      win  = '{32'hBEEF0000, 32'hCAFE0001, 32'h00000002, 32'hFFFF0003};
      wexp = '{32'hBEF00001, 32'hCAFF0002, 32'h00010003, 32'h00000004};
      run_batch(-1, cyc);
      check_val("ab_restart_latency", cyc, 13);
      check_tx("ab_restart");

      // asynchronous reset in the middle of WAIT
      set_lat(5, 5, 5, 5);
      prep();
      start = 1'b1;
      @(negedge bus_clk);
      start = 1'b0;
      repeat (7) @(negedge bus_clk);
      check_val("rst_pre_busy", busy, 1);
      #2;
      bus_rst_n = 1'b0;
      #1;
      check_val("rst_async_ctl", {busy, done, rx_rden, tx_wren, timeout_err, lane_in_valid}, '0);
      @(negedge bus_clk);
      bus_rst_n = 1'b1;
      repeat (10) @(negedge bus_clk);
      check_val("rst_stays_idle", {busy, done_cnt - done_base}, '0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
